md_issue_ctrl: RTL
==================

// Module: md_issue_ctrl
// PURPOSE
//  Issue/sequencing controller for the multicycle mult/div datapath in the P6 pipeline.
//  Accepts MD ops from the E stage, launches the datapath, counts its latency and owns HI/LO.
//  Raises busy/stall toward the D-stage hazard logic so dependent MD ops and MFHI/MFLO wait.
// PARAMETERS
//  MUL_CYCLES  5   cycles from accept to HI/LO update for MULT/MULTU/MADD (>=1)
//  DIV_CYCLES  10  cycles from accept to HI/LO update for DIV/DIVU (>=1)
//  CNT_W       4   down-counter width; must hold max(MUL_CYCLES,DIV_CYCLES)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  op_valid   in   1   E-stage MD op present this cycle
//  op_code    in   3   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MADD,6 MTHI,7 MTLO
//  op_a       in   32  rs operand (MTHI/MTLO source)
//  op_b       in   32  rt operand
//  d_use_md   in   1   D-stage instr is an MD op or MFHI/MFLO
//  dp_hi      in   32  datapath result high word (remainder for DIV)
//  dp_lo      in   32  datapath result low word (quotient for DIV)
//  dp_start   out  1   one-cycle launch pulse to datapath
//  dp_op      out  2   01 MUL, 10 DIV, 11 MADD (datapath computes product only); 00 idle
//  dp_signed  out  1   1 = signed operation
//  dp_a,dp_b  out  32  registered operands, held stable for the whole run
//  busy       out  1   unit occupied (registered state or accepting this cycle)
//  stall_d    out  1   busy & d_use_md
//  hi,lo      out  32  architectural HI/LO
//  err        out  1   sticky: op_valid with op_code!=0 arrived while in RUN
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, hi=lo=0, dp_a=dp_b=0, dp_op=0, dp_signed=0, err=0;
//   dp_start=0 (registered). Reset mid-run aborts; HI/LO are not written.
//  FSM IDLE/RUN. IDLE, op_valid, op_code 1..5: latch op_a/op_b -> dp_a/dp_b, set dp_op and
//   dp_signed (1 for MULT/DIV/MADD, 0 for MULTU/DIVU), dp_start=1 for the next cycle only,
//   cnt<=MUL_CYCLES or DIV_CYCLES, ->RUN.
//  IDLE, op_valid, op_code 6/7: hi (6) or lo (7) <= op_a at that edge; state stays IDLE.
//  RUN: cnt decrements each edge; on the edge where cnt==1: MUL: {hi,lo}<={dp_hi,dp_lo};
//   DIV: hi<=dp_hi, lo<=dp_lo; MADD: {hi,lo}<={hi,lo}+{dp_hi,dp_lo} (full 64-bit add, carry
//   lo->hi, wrap mod 2^64); then cnt<=0, dp_op<=0, ->IDLE.
//  Latency: op accepted at edge T -> HI/LO valid after edge T+N (N = MUL_/DIV_CYCLES).
//  busy = (state==RUN) | (state==IDLE & op_valid & op_code in 1..5); combinational.
//  busy deasserts in the cycle after the completing edge; a new op can be accepted then.
//  Op in RUN (pipeline violation): ignored; no state, HI/LO or operand change; err<=1.
//  MTHI/MTLO never start the datapath and never assert busy.
//  Divide by zero: no special case; whatever dp_hi/dp_lo present is captured.
//  op_code 0 with op_valid: no effect.
// TESTING
//  1 reset mid-RUN -> outputs at reset values immediately; hi=lo=0; no later HI/LO write.
//  2 MULT a=-3,b=7 -> dp_start 1 cycle, busy 5 cycles, then hi=FFFFFFFF, lo=FFFFFFEB.
//  3 DIVU a=100,b=7 -> busy 10 cycles; hi=2, lo=14; stall_d high whenever d_use_md=1 in RUN.
//  4 MTLO a=FFFFFFFF, MTHI a=0, then MADD a=1,b=1 -> hi=00000001, lo=00000000 (carry).
//  5 MULT issued, then op_valid DIV on 2nd RUN cycle -> ignored, err=1, MULT result intact.
//  6 DIV completes, MULT on next cycle -> accepted, no bubble beyond spec'd busy drop.

Source files
------------

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: E-stage op, datapath and HI/LO signals of the MD issue controller
interface md_issue_ctrl_if;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        d_use_md;
   logic [31:0] dp_hi;
   logic [31:0] dp_lo;
   logic        dp_start;
   logic [1:0]  dp_op;
   logic        dp_signed;
   logic [31:0] dp_a;
   logic [31:0] dp_b;
   logic        busy;
   logic        stall_d;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        err;
   modport master (
      output op_valid, op_code, op_a, op_b, d_use_md, dp_hi, dp_lo,
      input  dp_start, dp_op, dp_signed, dp_a, dp_b, busy, stall_d, hi, lo, err
   );
   modport slave (
      input  op_valid, op_code, op_a, op_b, d_use_md, dp_hi, dp_lo,
      output dp_start, dp_op, dp_signed, dp_a, dp_b, busy, stall_d, hi, lo, err
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: launches the multicycle mult/div datapath, times its latency and owns HI/LO
module md_issue_ctrl #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 4
) (
   input logic            clk,
   input logic            reset,
   md_issue_ctrl_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_md, is_div, accept;
   assign is_md     = bus.op_code != 3'd0 && bus.op_code <= 3'd5;
   assign is_div    = bus.op_code == 3'd3 || bus.op_code == 3'd4;
   assign accept    = state == IDLE && bus.op_valid && is_md;
   assign bus.busy    = state == RUN || accept;
   assign bus.stall_d = bus.busy && bus.d_use_md;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.hi        <= '0;
         bus.lo        <= '0;
         bus.dp_a      <= '0;
         bus.dp_b      <= '0;
         bus.dp_op     <= 2'b00;
         bus.dp_signed <= 1'b0;
         bus.dp_start  <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         bus.dp_start <= accept;
         if (accept) begin
            bus.dp_a      <= bus.op_a;
            bus.dp_b      <= bus.op_b;
            bus.dp_op     <= is_div ? 2'b10 : bus.op_code == 3'd5 ? 2'b11 : 2'b01;
            // odd codes (MULT, DIV, MADD) are the signed ones
            bus.dp_signed <= bus.op_code[0];
            cnt           <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state         <= RUN;
         end else if (state == IDLE && bus.op_valid && bus.op_code == 3'd6) begin
            bus.hi <= bus.op_a;
         end else if (state == IDLE && bus.op_valid && bus.op_code == 3'd7) begin
            bus.lo <= bus.op_a;
         end else if (state == RUN) begin
            if (bus.op_valid && bus.op_code != 3'd0) bus.err <= 1'b1;
            if (cnt == CNT_W'(1)) begin
               {bus.hi, bus.lo} <= bus.dp_op == 2'b11 ? {bus.hi, bus.lo} + {bus.dp_hi, bus.dp_lo}
                                                      : {bus.dp_hi, bus.dp_lo};
               cnt       <= '0;
               bus.dp_op <= 2'b00;
               state     <= IDLE;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
endmodule
